// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_rx_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with configurable reset value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic metaQ;
   logic syncQ;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         metaQ <= RST_VAL;
         syncQ <= RST_VAL;
      end else begin
         metaQ <= d;
         syncQ <= metaQ;
      end
   end

   assign q = syncQ;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output register and overrun reporting.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 majority of the synced line.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rx,
   input  logic                 i_abort,
   input  logic                 i_ready,
   output logic                 o_valid,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_par_err,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdxW = $clog2(DATA_BITS + 2);
   localparam logic [CntW-1:0] HalfCnt  = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] LastCnt  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
   localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

   logic rxS;
   logic abortS;
   logic sample;

   sync_2ff #(.RST_VAL(1'b1)) uRxSync (
      .clk (clk),
      .rst (rst),
      .d   (i_rx),
      .q   (rxS)
   );

   sync_2ff #(.RST_VAL(1'b0)) uAbortSync (
      .clk (clk),
      .rst (rst),
      .d   (i_abort),
      .q   (abortS)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] rxHistQ;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxHistQ <= 2'b11;
      end else begin
         rxHistQ <= {rxHistQ[0], rxS};
      end
   end

   assign sample = majority3(rxS, rxHistQ[0], rxHistQ[1]);
`else
   assign sample = rxS;
`endif

   uart_rx_state_t       stateQ, stateD;
   logic [CntW-1:0]      cntQ, cntD;
   logic [IdxW-1:0]      idxQ, idxD;
   logic [DATA_BITS-1:0] shiftQ, shiftD;
   logic                 parBitQ, parBitD;
   logic                 stopErrQ, stopErrD;
   logic                 done;
   logic                 doneParErr;
   logic                 doneFrameErr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ   <= StIdle;
         cntQ     <= '0;
         idxQ     <= '0;
         shiftQ   <= '0;
         parBitQ  <= 1'b0;
         stopErrQ <= 1'b0;
      end else begin
         stateQ   <= stateD;
         cntQ     <= cntD;
         idxQ     <= idxD;
         shiftQ   <= shiftD;
         parBitQ  <= parBitD;
         stopErrQ <= stopErrD;
      end
   end

   always_comb begin
      stateD   = stateQ;
      cntD     = cntQ;
      idxD     = idxQ;
      shiftD   = shiftQ;
      parBitD  = parBitQ;
      stopErrD = stopErrQ;
      done     = 1'b0;

      if (stateQ != StIdle) begin
         cntD = cntQ + CntW'(1);
      end

      unique case (stateQ)
         StIdle: begin
            cntD = '0;
            idxD = '0;
            if (!rxS && !abortS) begin
               stateD   = StStart;
               stopErrD = 1'b0;
            end
         end
         StStart: begin
            if (cntQ == HalfCnt) begin
               cntD   = '0;
               stateD = sample ? StIdle : StData;
            end
         end
         StData: begin
            if (cntQ == LastCnt) begin
               cntD   = '0;
               // LSB arrives first, so shifting right leaves bit 0 in shiftQ[0]
               shiftD = {sample, shiftQ[DATA_BITS-1:1]};
               if (idxQ == LastData) begin
                  idxD   = '0;
                  stateD = (PARITY == PAR_NONE) ? StStop : StParity;
               end else begin
                  idxD = idxQ + IdxW'(1);
               end
            end
         end
         StParity: begin
            if (cntQ == LastCnt) begin
               cntD    = '0;
               parBitD = sample;
               stateD  = StStop;
            end
         end
         StStop: begin
            if (cntQ == LastCnt) begin
               cntD = '0;
               if (!sample) begin
                  stopErrD = 1'b1;
               end
               if (idxQ == LastStop) begin
                  idxD   = '0;
                  done   = 1'b1;
                  stateD = StIdle;
               end else begin
                  idxD = idxQ + IdxW'(1);
               end
            end
         end
         default: stateD = StIdle;
      endcase

      // Abort wins over everything, including a completing stop sample
      if (abortS) begin
         stateD = StIdle;
         cntD   = '0;
         idxD   = '0;
         done   = 1'b0;
      end
   end

   assign doneFrameErr = stopErrQ | ~sample;
   assign doneParErr   = (PARITY != PAR_NONE) && ((^shiftQ ^ parBitQ) != (PARITY == PAR_ODD));

   logic                 validQ, validD;
   logic [DATA_BITS-1:0] dataQ, dataD;
   logic                 parErrQ, parErrD;
   logic                 frameErrQ, frameErrD;
   logic                 overrunQ, overrunD;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         validQ    <= 1'b0;
         dataQ     <= '0;
         parErrQ   <= 1'b0;
         frameErrQ <= 1'b0;
         overrunQ  <= 1'b0;
      end else begin
         validQ    <= validD;
         dataQ     <= dataD;
         parErrQ   <= parErrD;
         frameErrQ <= frameErrD;
         overrunQ  <= overrunD;
      end
   end

   always_comb begin
      validD    = validQ;
      dataD     = dataQ;
      parErrD   = parErrQ;
      frameErrD = frameErrQ;
      overrunD  = 1'b0;

      if (validQ && i_ready) begin
         validD = 1'b0;
      end

      if (done) begin
         if (!validQ || i_ready) begin
            validD    = 1'b1;
            dataD     = shiftQ;
            parErrD   = doneParErr;
            frameErrD = doneFrameErr;
         end else begin
            overrunD = 1'b1;
         end
      end
   end

   assign o_valid     = validQ;
   assign o_data      = dataQ;
   assign o_par_err   = parErrQ;
   assign o_frame_err = frameErrQ;
   assign o_overrun   = overrunQ;
   assign o_busy      = (stateQ != StIdle);

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: oversampled start detection, configurable data width, optional parity, 1 or 2 stop bits, per-frame error flags and a valid/ready output register with overrun reporting. It sits between the board RX pin and the frame-parsing logic. An external abort input, driven from the transmit side, cancels a frame in progress.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per bit; even, ≥ 4.
- DATA_BITS, default 8: data bits per frame, 5..9, LSB first.
- PARITY, default 0: 0 none, 1 odd, 2 even.
- STOP_BITS, default 1: 1 or 2.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_rx  input  1  asynchronous serial line; idles high.
- i_abort  input  1  asynchronous; while high (after sync), cancels reception.
- i_ready  input  1  consumer accepts o_data when o_valid && i_ready.
- o_valid  output  1  received frame held in output register.
- o_data  output  DATA_BITS  received data.
- o_par_err  output  1  parity mismatch for held frame; 0 when PARITY=0.
- o_frame_err  output  1  a stop bit sampled low for held frame.
- o_overrun  output  1  one-cycle pulse: completed frame dropped.
- o_busy  output  1  FSM not in IDLE.

## Operation
- i_rx and i_abort each pass through a 2-flop synchronizer (reset value 1 for rx, 0 for abort). rx_s and abort_s denote the synchronized values.
- FSM states, in order: IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP, back to IDLE.
- IDLE: if rx_s==0 and abort_s==0, clear the bit counter and go to START.
- START: at count CLKS_PER_BIT/2−1, sample the line. If it is low, go to DATA. If it is high, this is a false start: return to IDLE with no output.
- DATA: sample every CLKS_PER_BIT cycles into shift register bit idx, with idx running 0..DATA_BITS−1.
- PARITY: sample one bit. Error = (XOR of data ^ parity bit) != (PARITY==1 ? 1 : 0).
- STOP: sample STOP_BITS bits; any 0 sets the frame error.
- The frame completes on the last stop sample, then FSM goes to IDLE the same cycle. A new start can be detected from the next cycle on.
- Completion when the output register is free (!o_valid, or o_valid && i_ready in the same cycle): load o_data, o_par_err and o_frame_err, and set o_valid. A frame with errors is still delivered, with its flags set.
- Completion when o_valid && !i_ready: drop the new frame, pulse o_overrun, and leave the held register unchanged.
- Handshake: o_valid, o_data and the flags stay stable until o_valid && i_ready. On acceptance o_valid clears next cycle, unless a new frame loads in that same cycle, in which case o_valid stays 1 with the new data.
- Abort: abort_s==1 forces IDLE in any state from the next cycle. The partial frame is discarded and no flags are raised. The output register is unaffected.
- Reset mid-frame: all state returns to reset values immediately.

## Timing
- All outputs reset to 0; FSM resets to IDLE; counters reset to 0.
- Sample points, with t0 = first cycle in START:
  - start bit at t0 + CLKS_PER_BIT/2 − 1;
  - bit k (data, then parity, then stop) at that point + (k+1)·CLKS_PER_BIT.
- o_valid rises 1 cycle after the final stop sample.
- Pin-to-o_valid latency from the start-bit falling edge: 2 sync cycles + 1 (IDLE→START) + (frame bits − 0.5)·CLKS_PER_BIT, ±1 cycle of sync phase.
- Bit-cycle counter width: $clog2(CLKS_PER_BIT). Bit index width: $clog2(DATA_BITS+2). Both wrap to 0 at every sample point.

## Configuration
- UART_RX_MAJORITY_EN defined: each sample is the 2-of-3 majority of rx_s at the sample cycle and the two preceding cycles. This applies to the start check too.
- UART_RX_MAJORITY_EN undefined: each sample is the single rx_s value at the sample cycle.
- Sample timing is identical in both builds.

## Structure
- Package uart_pkg:
  - state enum uart_rx_state_t;
  - parity localparams PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
- Sub-module sync_2ff (parameter RST_VAL), instantiated for i_rx and i_abort.

## Test plan
Bench configuration for all cases: CLKS_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1, i_ready=1 unless noted.
- Frame 0xA5 with parity bit 0 and stop 1 -> one o_valid with o_data=0xA5, par_err=0, frame_err=0, at the latency given above.
- Frame 0xA5 with parity bit 1 -> o_data=0xA5, o_par_err=1.
- Frame 0x3C with stop bit driven 0 -> o_data=0x3C, o_frame_err=1; a following frame 0x55 is received cleanly.
- rx low glitch of 4 cycles -> o_busy pulses, no o_valid.
- i_ready=0, frames 0x11 then 0x22 -> o_data=0x11 held, o_overrun pulses once at 0x22 completion; after i_ready=1, o_valid clears.
- i_abort pulse after 3 data bits of 0xFF -> no o_valid; next frame 0x3C is received correctly.
